// File: rtl/oddr_serializer.sv
// Multi-lane parallel-to-serial front end feeding ODDR D1/D2 pins.
// It has a one-word holding buffer so that words stream without gaps, and a DDR or SDR slot rate.
module oddr_serializer #(
    parameter int          CHANNELS   = 1,
    parameter int          DATA_WIDTH = 8,
    parameter string       DATA_RATE  = "DDR",
    parameter string       BIT_ORDER  = "LSB_FIRST",
    parameter logic        INIT       = 1'b0
) (
    input  logic                           C,
    input  logic                           R,
    input  logic                           CE,
    input  logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    output logic [CHANNELS-1:0]            D1,
    output logic [CHANNELS-1:0]            D2,
    output logic                           OCE,
    output logic                           BUSY,
    output logic                           UNDERRUN
);

    localparam int TOT   = CHANNELS * DATA_WIDTH;
    localparam int BPC   = (DATA_RATE == "SDR") ? 1 : 2;
    localparam int N     = DATA_WIDTH / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam bit MSB   = (BIT_ORDER == "MSB_FIRST");
    // The head bits stay at fixed positions; the lane shifts toward them.
    localparam int IDX1  = MSB ? DATA_WIDTH - 1 : 0;
    localparam int IDX2  = (BPC == 1) ? IDX1 : (MSB ? DATA_WIDTH - 2 : 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [TOT-1:0]   r_shift, w_shift_nxt;
    logic [TOT-1:0]   r_hold, w_hold_nxt;
    logic             r_hold_valid, w_hold_valid_nxt;
    logic             r_underrun, w_underrun_nxt;
    logic             w_load, w_accept;

    function automatic logic [TOT-1:0] advance(input logic [TOT-1:0] s);
        logic [TOT-1:0]        res;
        logic [DATA_WIDTH-1:0] lane;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            lane = s[k*DATA_WIDTH +: DATA_WIDTH];
            if (MSB) begin
                lane = lane << BPC;
            end else begin
                lane = lane >> BPC;
            end
            res[k*DATA_WIDTH +: DATA_WIDTH] = lane;
        end
        return res;
    endfunction

    assign w_load   = r_hold_valid && ((r_state == ST_IDLE) || (r_cnt == LAST_CNT));
    assign IN_READY = !R && CE && (!r_hold_valid || w_load);
    assign w_accept = IN_VALID && IN_READY;

    // Next-state: hold buffer, slot counter, shift register and end-of-stream pulse
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_hold_nxt       = w_accept ? IN_DATA : r_hold;
        w_hold_valid_nxt = w_accept || (r_hold_valid && !w_load);
        w_underrun_nxt   = 1'b0;
        if (w_load) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
            w_shift_nxt = r_hold;
        end else if (r_state == ST_ACTIVE) begin
            if (r_cnt == LAST_CNT) begin
                w_state_nxt    = ST_IDLE;
                w_cnt_nxt      = '0;
                w_underrun_nxt = 1'b1;
            end else begin
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                w_shift_nxt = advance(r_shift);
            end
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State registers; CE low freezes everything except the underrun pulse
    always_ff @(posedge C) begin
        if (R) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (CE) begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_underrun   <= w_underrun_nxt;
        end else begin
            r_underrun   <= 1'b0;
        end
    end

    // Pin drive: the shift-register head while active, otherwise the idle level
    always_comb begin
        D1 = {CHANNELS{INIT}};
        D2 = {CHANNELS{INIT}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_state == ST_ACTIVE) begin
                D1[k] = r_shift[k*DATA_WIDTH + IDX1];
                D2[k] = r_shift[k*DATA_WIDTH + IDX2];
            end else begin
                D1[k] = INIT;
                D2[k] = INIT;
            end
        end
    end

    assign OCE      = (r_state == ST_ACTIVE);
    assign BUSY     = r_hold_valid || (r_state == ST_ACTIVE);
    assign UNDERRUN = r_underrun;

endmodule

// File: doc/oddr_serializer.md
Name: oddr_serializer

Overview:
Parametrised multi-channel parallel-to-serial front end that feeds per-channel ODDR D1/D2 pins. It generalises the single-bit ODDR path to DATA_WIDTH-bit words across CHANNELS lanes, in DDR (2 bits/cycle) or SDR (1 bit/cycle) mode. A valid/ready word handshake and a one-word holding buffer give gapless streaming. It sits between fabric packet logic and the IOB ODDR instances.

Parameters:
CHANNELS, 1, number of lanes; all lanes share the handshake and slot counter.
DATA_WIDTH, 8, bits per word per lane; range 2..16; must be even when DATA_RATE="DDR".
DATA_RATE, "DDR", "DDR" emits 2 bits per cycle; "SDR" emits 1 bit per cycle.
BIT_ORDER, "LSB_FIRST", "LSB_FIRST" or "MSB_FIRST"; sets the serialisation order.
INIT, 0, idle and reset level driven on D1/D2.

Ports:
C  input  1  clock, single domain, rising edge only.
R  input  1  reset, synchronous, active-high.
CE  input  1  clock enable; when low, all state freezes.
IN_DATA  input  CHANNELS*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
IN_VALID  input  1  word valid.
IN_READY  output  1  word accepted on an edge where IN_VALID && IN_READY.
D1  output  CHANNELS  first-half bit per lane (to ODDR D1).
D2  output  CHANNELS  second-half bit per lane (to ODDR D2).
OCE  output  1  high while D1/D2 carry word data (to ODDR CE).
BUSY  output  1  high when the shift register or the hold buffer is occupied.
UNDERRUN  output  1  one-cycle pulse when a word ends with no successor queued.

Behaviour:
- BPC = 2 for DDR, 1 for SDR. Slots per word N = DATA_WIDTH/BPC.
- Storage: per-lane hold register plus hold_valid; per-lane shift register; slot counter cnt of width clog2(N), minimum 1 bit; state IDLE/ACTIVE.
- Acceptance:
  - IN_READY = !R && CE && (!hold_valid || load).
  - load = hold_valid && (state==IDLE || cnt==N-1).
  - IN_READY is combinational, so a word can be accepted in the same cycle the hold buffer drains. N=1 therefore sustains one word per cycle.
- On a load edge:
  - The shift register takes the hold word.
  - cnt = 0 and state goes to ACTIVE.
  - hold_valid clears, unless a new word is accepted on the same edge, in which case it stays 1 with the new word.
- In ACTIVE without load, cnt increments each CE edge. At cnt==N-1 with no hold word, state goes to IDLE.
- Output mapping:
  - D1/D2 are driven directly from the shift-register head.
  - LSB_FIRST, slot s: D1 = bit BPC*s, D2 = bit BPC*s+1.
  - MSB_FIRST mirrors the indices (D1 = bit W-1-BPC*s, and so on).
  - SDR: D2 = D1, so the pad holds the bit for the whole cycle.
- Latency: a word accepted at edge k while IDLE presents slot 0 after edge k+1. Back-to-back words have zero idle slots between them.
- When IDLE, D1 = D2 = INIT and OCE = 0. OCE = 1 exactly during ACTIVE slots.
- UNDERRUN is registered. It is 1 for the cycle after an edge that transitions ACTIVE to IDLE, and 0 otherwise.
- CE low: no acceptance (IN_READY=0), and cnt, state, shift, hold and outputs hold their values. UNDERRUN drops to 0.
- R high at an edge, regardless of CE:
  - hold_valid=0, state=IDLE, cnt=0.
  - D1=D2=INIT, OCE=0, BUSY=0, UNDERRUN=0.
  - A word in flight is discarded, with no UNDERRUN pulse.
  - R dominates a simultaneous IN_VALID, and IN_READY=0 while R is high.
- BUSY = hold_valid || state==ACTIVE.
- Never emits partial words. Slot order within a word is never altered by stalls.

Test Plan:
- DDR, W=8, CH=1, LSB_FIRST: send 0xA5 once -> after 1 cycle of latency, (D1,D2) = (1,0),(1,0),(0,1),(0,1) with OCE=1 for 4 cycles, then D1=D2=INIT, OCE=0, and UNDERRUN=1 for 1 cycle.
- Same config, 0xA5 then 0x3C with IN_VALID held -> 8 contiguous OCE cycles, second word pairs (0,0),(1,1),(1,1),(0,0), no UNDERRUN between words, exactly one UNDERRUN after.
- SDR, W=4, MSB_FIRST: 4'b1001 -> D1=D2 sequence 1,0,0,1, then INIT.
- CH=2, DDR, W=2 (N=1): stream 0b10/0b01 per lane every cycle for 6 cycles -> IN_READY stays 1, OCE high for 6 consecutive cycles, each lane output matches its word each cycle.
- DDR W=8: deassert CE for 3 cycles during slot 2 -> D1/D2/OCE frozen for those cycles, IN_READY=0, remaining slots 2..3 resume intact.
- Assert R during slot 1 with a second word held -> next cycle OCE=0, D1=D2=INIT, BUSY=0, no UNDERRUN; a subsequent word serialises correctly from slot 0.
